fir_mac_sequencer: RTL and testbench



---
 rtl/fir_mac_if.sv | 21 ++
 rtl/fir_mac_sequencer.sv | 90 +++++++++
 tb/tb_fir_mac_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/fir_mac_if.sv
// fir_mac_if: sample, result and coefficient-write signals of fir_mac_sequencer
interface fir_mac_if #(parameter int WIDTH = 9);
  logic in_valid;
  logic in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic coef_we;
  logic [5:0] coef_addr;
  logic signed [WIDTH-1:0] coef_wdata;
  logic busy;
  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input in_ready, out_valid, out_data, busy
  );
  modport slave (
    input in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: time-multiplexed FIR, one signed MAC per clock; define FIR_OUT_SAT_EN to saturate out_data
module fir_mac_sequencer #(
  parameter int WIDTH = 9,
  parameter int TAPS  = 33,
  parameter int ACC_W = 24,
  parameter int FRAC  = 8
) (
  input logic clk,
  input logic rst,
  fir_mac_if.slave bus
);
  localparam int AW = 6;
  localparam int TW = ACC_W - FRAC;
  localparam int DEF_C [TAPS] = '{0, -1, 1, 0, -1, 2, 0, -2, 2, 0, -6, 8, 10, -28, -14, 111, 196,
                                  111, -14, -28, 10, 8, -6, 0, 2, -2, 0, 2, -1, 0, 1, -1, 0};
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] k_q, k_d, wptr_q, wptr_d, rd_idx;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_mac;
  logic signed [WIDTH-1:0] out_q, out_d, trunc_out;
  logic signed [WIDTH-1:0] hist_q [TAPS];
  logic signed [WIDTH-1:0] coef_q [TAPS];
  logic signed [2*WIDTH-1:0] prod;
  logic signed [TW-1:0] trunc;
  logic accept;
  assign accept = bus.in_valid && state_q == IDLE;
  // (wptr - k) mod TAPS; the 6-bit intermediate may wrap but the result lands in 0..TAPS-1
  assign rd_idx = wptr_q >= k_q ? wptr_q - k_q : wptr_q + AW'(TAPS) - k_q;
  assign prod = coef_q[k_q] * hist_q[rd_idx];
  assign acc_mac = acc_q + ACC_W'(prod);
  assign trunc = acc_mac[ACC_W-1:FRAC];
`ifdef FIR_OUT_SAT_EN
  localparam logic signed [TW-1:0] MAX_V = TW'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [TW-1:0] MIN_V = TW'(-(2 ** (WIDTH - 1)));
  assign trunc_out = trunc > MAX_V ? WIDTH'(MAX_V) : trunc < MIN_V ? WIDTH'(MIN_V) : trunc[WIDTH-1:0];
`else
  assign trunc_out = {trunc[TW-1], trunc[WIDTH-2:0]};
`endif
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_data = out_q;
  assign bus.busy = state_q != IDLE;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    acc_d = acc_q;
    wptr_d = wptr_q;
    out_d = out_q;
    case (state_q)
      IDLE: if (accept) begin
        acc_d = '0;
        k_d = '0;
        state_d = MAC;
      end
      MAC: begin
        acc_d = acc_mac;
        k_d = k_q + AW'(1);
        if (k_q == AW'(TAPS - 1)) begin
          wptr_d = wptr_q == AW'(TAPS - 1) ? '0 : wptr_q + AW'(1);
          out_d = trunc_out;
          state_d = OUT;
        end
      end
      OUT: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= '0;
      acc_q <= '0;
      wptr_q <= '0;
      out_q <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= WIDTH'(DEF_C[i]);
      end
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      acc_q <= acc_d;
      wptr_q <= wptr_d;
      out_q <= out_d;
      if (accept) hist_q[wptr_q] <= bus.in_data;
      // coefficient table only changes while idle, so a MAC pass never sees a mixed table
      if (bus.coef_we && state_q == IDLE && bus.coef_addr < AW'(TAPS)) coef_q[bus.coef_addr] <= bus.coef_wdata;
    end
  end
endmodule

// File: tb/tb_fir_mac_sequencer.sv
// tb_fir_mac_sequencer: random and directed stimulus, scoreboard against a convolution model
module tb_fir_mac_sequencer;
  localparam int DEFC [33] = '{0, -1, 1, 0, -1, 2, 0, -2, 2, 0, -6, 8, 10, -28, -14, 111, 196,
                               111, -14, -28, 10, 8, -6, 0, 2, -2, 0, 2, -1, 0, 1, -1, 0};
  logic clk = 0;
  logic rst = 1;
  logic rand_ready = 0;
  logic force_ready = 1;
  logic rnd_rdy = 1;
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int last_out = 0;
  int held = 0;
  bit ov_prev = 0;
  int exp_q[$];
  int lat_q[$];
  int xs[$];
  int mc [33];
  fir_mac_if #(.WIDTH(9)) bus();
  fir_mac_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.out_ready = rand_ready ? rnd_rdy : force_ready;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);
  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end
  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask
  // y[n] = sum c[k]*x[n-k], floor-divided by 256, then mapped to 9 bits
  function automatic int model_out();
    int acc;
    int tr;
`ifndef FIR_OUT_SAT_EN
    logic [15:0] t;
`endif
    acc = 0;
    for (int k = 0; k < 33; k++)
      if (k < xs.size()) acc += mc[k] * xs[xs.size() - 1 - k];
    tr = acc >>> 8;
`ifdef FIR_OUT_SAT_EN
    return tr > 255 ? 255 : tr < -256 ? -256 : tr;
`else
    t = tr[15:0];
    return t[15] ? int'(t[7:0]) - 256 : int'(t[7:0]);
`endif
  endfunction
  task automatic model_reset();
    xs.delete();
    exp_q.delete();
    lat_q.delete();
    foreach (mc[i]) mc[i] = DEFC[i];
  endtask
  task automatic send(input int x, output int waits);
    bus.in_valid = 1;
    bus.in_data = 9'(x);
    waits = 0;
    while (!bus.in_ready && waits < 300) begin
      @(negedge clk);
      waits++;
    end
    check("in_ready", bus.in_ready, 1);
    xs.push_back(x);
    if (xs.size() > 33) void'(xs.pop_front());
    exp_q.push_back(model_out());
    lat_q.push_back(cyc);
    @(negedge clk);
    bus.in_valid = 0;
  endtask
  task automatic wr(input int a, input int d, input bit idle);
    bus.coef_we = 1;
    bus.coef_addr = 6'(a);
    bus.coef_wdata = 9'(d);
    if (idle && a < 33) mc[a] = d;
    @(negedge clk);
    bus.coef_we = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask
  task automatic impulse(input int amp);
    int w;
    send(amp, w);
    repeat (32) send(0, w);
    drain();
  endtask
  initial forever begin
    @(negedge clk);
    #1;
    if (rst) ov_prev = 0;
    else begin
      if (bus.out_valid && !ov_prev) begin
        if (lat_q.size() == 0) check("unexpected_valid", bus.out_valid, 0);
        else check("latency", cyc - lat_q.pop_front(), 34);
        held = bus.out_data;
      end else if (bus.out_valid) check("hold", bus.out_data, held);
      ov_prev = bus.out_valid;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", bus.out_valid, 0);
        else check("out_data", bus.out_data, exp_q.pop_front());
        last_out = bus.out_data;
        ov_prev = 0;
      end
    end
  end
  initial begin
    int w;
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.coef_we = 0;
    bus.coef_addr = 0;
    bus.coef_wdata = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_busy", bus.busy, 0);
    rst = 0;
    @(negedge clk);
    impulse(128);
    repeat (33) send(255, w);
    drain();
`ifdef FIR_OUT_SAT_EN
    check("dc_out", last_out, 255);
`else
    check("dc_out", last_out, 102);
`endif
    force_ready = 0;
    send(50, w);
    bus.in_valid = 1;
    bus.in_data = 77;
    w = 0;
    while (!bus.out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    force_ready = 1;
    send(77, w);
    check("bp_accept_wait", w, 1);
    drain();
    wr(16, 0, 1);
    impulse(128);
    send(128, w);
    wr(15, 5, 0);
    repeat (32) send(0, w);
    drain();
    wr(40, 99, 1);
    send(128, w);
    repeat (10) @(negedge clk);
    rst = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    rst = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("mid_rst_no_valid", bus.out_valid, 0);
    end
    check("mid_rst_in_ready", bus.in_ready, 1);
    impulse(128);
    for (int i = 0; i < 4; i++) begin
      send(128, w);
      repeat (39) send(0, w);
    end
    drain();
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        drain();
        wr(int'($urandom_range(0, 40)), int'($urandom_range(0, 511)) - 256, 1);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(int'($urandom_range(0, 511)) - 256, w);
    end
    drain();
    rand_ready = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
